top_level_calc_cordic: RTL and testbench

TOP_LEVEL_CALC_CORDIC -- requirements
Module: top_level_calc_cordic

---
 rtl/top_level_calc_cordic_pkg.sv | 88 ++++++++
 rtl/top_level_calc_cordic_core.sv | 76 +++++++
 rtl/top_level_calc_cordic.sv | 154 +++++++++++++++
 tb/tb_top_level_calc_cordic.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/top_level_calc_cordic_pkg.sv
// Shared definitions for the CORDIC calculator: operation codes, FSM and
// mode types, Q16.16 angle tables and gain-compensation constants.
// Hyperbolic helpers are always present here; they are only referenced when
// CORDIC_HYPERBOLIC_EN is defined.
package top_level_calc_cordic_pkg;

  localparam int unsigned FRAC_BITS = 16;

  localparam logic [3:0] OP_SIN     = 4'd0;
  localparam logic [3:0] OP_COS     = 4'd1;
  localparam logic [3:0] OP_ATAN    = 4'd2;
  localparam logic [3:0] OP_MOD     = 4'd3;
  localparam logic [3:0] OP_MULT    = 4'd4;
  localparam logic [3:0] OP_DIV     = 4'd5;
  localparam logic [3:0] OP_SINH    = 4'd6;
  localparam logic [3:0] OP_COSH    = 4'd7;
  localparam logic [3:0] OP_ATANH   = 4'd8;
  localparam logic [3:0] OP_MODH    = 4'd9;
  localparam logic [3:0] OP_DEFAULT = 4'd15;

  typedef enum logic [1:0] {ST_IDLE, ST_INIT, ST_ITER, ST_DONE} state_e;
  typedef enum logic [1:0] {MODE_CIRC, MODE_LIN, MODE_HYP} mode_e;

  // 1/K (0.607253) and 1/Kh (1.207497) in Q16.16
  localparam logic signed [31:0] INV_K  = 32'sd39797;
  localparam logic signed [31:0] INV_KH = 32'sd79135;

  // atan(2^-i) in Q16.16
  function automatic logic signed [31:0] atan_tab(input int unsigned i);
    case (i)
      0:  return 32'sd51472;
      1:  return 32'sd30385;
      2:  return 32'sd16055;
      3:  return 32'sd8150;
      4:  return 32'sd4091;
      5:  return 32'sd2047;
      6:  return 32'sd1024;
      7:  return 32'sd512;
      8:  return 32'sd256;
      9:  return 32'sd128;
      10: return 32'sd64;
      11: return 32'sd32;
      12: return 32'sd16;
      13: return 32'sd8;
      14: return 32'sd4;
      15: return 32'sd2;
      16: return 32'sd1;
      default: return '0;
    endcase
  endfunction

  // atanh(2^-s) in Q16.16, indexed by shift s (s=0 never used)
  function automatic logic signed [31:0] atanh_tab(input int unsigned s);
    case (s)
      1:  return 32'sd36000;
      2:  return 32'sd16739;
      3:  return 32'sd8235;
      4:  return 32'sd4101;
      5:  return 32'sd2049;
      6:  return 32'sd1024;
      7:  return 32'sd512;
      8:  return 32'sd256;
      9:  return 32'sd128;
      10: return 32'sd64;
      11: return 32'sd32;
      12: return 32'sd16;
      13: return 32'sd8;
      14: return 32'sd4;
      15: return 32'sd2;
      16: return 32'sd1;
      default: return '0;
    endcase
  endfunction

  // 2^-i in Q16.16 for linear mode
  function automatic logic signed [31:0] lin_tab(input int unsigned i);
    if (i > FRAC_BITS) return '0;
    return 32'sd1 <<< (FRAC_BITS - i);
  endfunction

  // Hyperbolic shift for iteration k: 1,2,3,4,4,5,...,13,13,14,...
  function automatic int unsigned hyp_shift(input int unsigned k);
    if (k >= 14) return k - 1;
    if (k >= 4)  return k;
    return k + 1;
  endfunction

endpackage

// File: rtl/top_level_calc_cordic_core.sv
// cordic_core: one micro-rotation per step in circular, linear or hyperbolic
// mode, rotation or vectoring. Hyperbolic mode exists only when
// CORDIC_HYPERBOLIC_EN is defined.
module cordic_core import top_level_calc_cordic_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_i,
  input  logic                    step_i,
  input  mode_e                   mode_i,
  input  logic                    vect_i,
  input  logic [CNT_W-1:0]        iter_i,
  input  logic signed [WIDTH-1:0] x0_i,
  input  logic signed [WIDTH-1:0] y0_i,
  input  logic signed [WIDTH-1:0] z0_i,
  output logic signed [WIDTH-1:0] x_o,
  output logic signed [WIDTH-1:0] y_o,
  output logic signed [WIDTH-1:0] z_o
);

  logic signed [WIDTH-1:0] x_q, y_q, z_q, x_d, y_d, z_d;
  logic signed [WIDTH-1:0] xs, ys, ang;
  int unsigned             idx, sh;
  logic                    pos;

  // One micro-rotation; pos selects direction +1 (z>=0 rotating, y<0 vectoring)
  always_comb begin
    idx = 32'(iter_i);
    sh  = idx;
    ang = WIDTH'(atan_tab(idx));
    case (mode_i)
      MODE_LIN: ang = WIDTH'(lin_tab(idx));
`ifdef CORDIC_HYPERBOLIC_EN
      MODE_HYP: begin
        sh  = hyp_shift(idx);
        ang = WIDTH'(atanh_tab(sh));
      end
`endif
      default: ;
    endcase
    xs  = x_q >>> sh;
    ys  = y_q >>> sh;
    pos = vect_i ? y_q[WIDTH-1] : ~z_q[WIDTH-1];
    y_d = pos ? y_q + xs  : y_q - xs;
    z_d = pos ? z_q - ang : z_q + ang;
    x_d = x_q;
    if (mode_i == MODE_CIRC) x_d = pos ? x_q - ys : x_q + ys;
`ifdef CORDIC_HYPERBOLIC_EN
    else if (mode_i == MODE_HYP) x_d = pos ? x_q + ys : x_q - ys;
`endif
  end

  // Working registers: load initial vector, then step once per iteration
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
      z_q <= '0;
    end else if (load_i) begin
      x_q <= x0_i;
      y_q <= y0_i;
      z_q <= z0_i;
    end else if (step_i) begin
      x_q <= x_d;
      y_q <= y_d;
      z_q <= z_d;
    end
  end

  assign x_o = x_q;
  assign y_o = y_q;
  assign z_o = z_q;

endmodule

// File: rtl/top_level_calc_cordic.sv
// CORDIC calculator top: operation decode, initial vector selection, control
// FSM and result selection. Codes 6-9 (hyperbolic) are implemented only when
// CORDIC_HYPERBOLIC_EN is defined; otherwise they return 0 like unused codes.
module top_level_calc_cordic import top_level_calc_cordic_pkg::*; #(
  parameter int WIDTH      = 32,
  parameter int ITERATIONS = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [3:0]              operation,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic signed [WIDTH-1:0] y_in,
  input  logic signed [WIDTH-1:0] z_in,
  output logic signed [WIDTH-1:0] result,
  output logic                    done
);

  localparam int CNT_W = $clog2(ITERATIONS + 1);
  localparam logic signed [WIDTH-1:0] INV_K_W = WIDTH'(INV_K);
`ifdef CORDIC_HYPERBOLIC_EN
  localparam logic signed [WIDTH-1:0] INV_KH_W = WIDTH'(INV_KH);
`endif

  state_e                  state_q, state_d;
  logic [3:0]              op_q, op_d;
  logic signed [WIDTH-1:0] ax_q, ay_q, az_q, ax_d, ay_d, az_d;
  logic [CNT_W-1:0]        iter_q, iter_d;
  logic signed [WIDTH-1:0] result_q, result_d;
  logic                    done_q, done_d;

  logic                    core_load, core_step, vect;
  mode_e                   mode;
  logic signed [WIDTH-1:0] x0, y0, z0, cx, cy, cz, sel, gain_k;
  logic signed [2*WIDTH-1:0] prod;

  cordic_core #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_core (
    .clk    (clk),
    .rst    (rst),
    .load_i (core_load),
    .step_i (core_step),
    .mode_i (mode),
    .vect_i (vect),
    .iter_i (iter_q),
    .x0_i   (x0),
    .y0_i   (y0),
    .z0_i   (z0),
    .x_o    (cx),
    .y_o    (cy),
    .z_o    (cz)
  );

  // Decode latched operation into mode, initial vector and result selection
  always_comb begin
    mode   = MODE_CIRC;
    vect   = 1'b0;
    x0     = '0;
    y0     = '0;
    z0     = '0;
    gain_k = INV_K_W;
`ifdef CORDIC_HYPERBOLIC_EN
    if (op_q == OP_MODH) gain_k = INV_KH_W;
`endif
    prod = (2*WIDTH)'(cx) * (2*WIDTH)'(gain_k);
    sel  = '0;
    case (op_q)
      OP_SIN:  begin x0 = INV_K_W; z0 = az_q; sel = cy; end
      OP_COS:  begin x0 = INV_K_W; z0 = az_q; sel = cx; end
      OP_ATAN: begin vect = 1'b1; x0 = ax_q; y0 = ay_q; sel = cz; end
      OP_MOD:  begin vect = 1'b1; x0 = ax_q; y0 = ay_q; sel = WIDTH'(prod >>> FRAC_BITS); end
      OP_MULT: begin mode = MODE_LIN; x0 = ax_q; z0 = az_q; sel = cy; end
      OP_DIV:  begin mode = MODE_LIN; vect = 1'b1; x0 = ax_q; y0 = ay_q; sel = cz; end
`ifdef CORDIC_HYPERBOLIC_EN
      OP_SINH: begin mode = MODE_HYP; x0 = INV_KH_W; z0 = az_q; sel = cy; end
      OP_COSH: begin mode = MODE_HYP; x0 = INV_KH_W; z0 = az_q; sel = cx; end
      OP_ATANH: begin mode = MODE_HYP; vect = 1'b1; x0 = ax_q; y0 = ay_q; sel = cz; end
      OP_MODH: begin
        mode = MODE_HYP; vect = 1'b1; x0 = ax_q; y0 = ay_q;
        sel  = WIDTH'(prod >>> FRAC_BITS);
      end
`endif
      default: ;
    endcase
  end

  // Control FSM: result is captured on the first DONE cycle, giving the
  // extra cycle of latency between the last iteration and done
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    ax_d      = ax_q;
    ay_d      = ay_q;
    az_d      = az_q;
    iter_d    = iter_q;
    result_d  = result_q;
    done_d    = done_q;
    core_load = 1'b0;
    core_step = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (state_q == ST_DONE && !done_q) begin
          result_d = sel;
          done_d   = 1'b1;
        end
        if (enable) begin
          state_d = ST_INIT;
          op_d    = operation;
          ax_d    = x_in;
          ay_d    = y_in;
          az_d    = z_in;
          done_d  = 1'b0;
        end
      end
      ST_INIT: begin
        core_load = 1'b1;
        iter_d    = '0;
        state_d   = ST_ITER;
      end
      ST_ITER: begin
        core_step = 1'b1;
        iter_d    = iter_q + 1'b1;
        if (iter_q == CNT_W'(ITERATIONS - 1)) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and operand registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      ax_q     <= '0;
      ay_q     <= '0;
      az_q     <= '0;
      iter_q   <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      ax_q     <= ax_d;
      ay_q     <= ay_d;
      az_q     <= az_d;
      iter_q   <= iter_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign done   = done_q;

endmodule

// File: tb/tb_top_level_calc_cordic.sv
// Self-checking bench for top_level_calc_cordic: directed cases, reset and
// enable behaviour, and randomized operations against a real-math model.
module tb_top_level_calc_cordic;

  localparam int W   = 32;
  localparam int N   = 16;
  localparam int TOL = 65;
`ifdef CORDIC_HYPERBOLIC_EN
  localparam bit HYP = 1'b1;
`else
  localparam bit HYP = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic                enable;
  logic [3:0]          operation;
  logic signed [W-1:0] x_in, y_in, z_in;
  logic signed [W-1:0] result;
  logic                done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  top_level_calc_cordic #(.WIDTH(W), .ITERATIONS(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .operation (operation),
    .x_in      (x_in),
    .y_in      (y_in),
    .z_in      (z_in),
    .result    (result),
    .done      (done)
  );

  task automatic check(input string tag, input longint got, input longint exp, input longint tol);
    longint diff;
    checks++;
    diff = got - exp;
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  function automatic int q(input real r);
    return $rtoi(r * 65536.0 + ((r >= 0.0) ? 0.5 : -0.5));
  endfunction

  function automatic real rv(input int v);
    return real'(v) / 65536.0;
  endfunction

  function automatic real urange(input real lo, input real hi);
    return lo + (hi - lo) * real'($urandom_range(0, 100000)) / 100000.0;
  endfunction

  function automatic bit unused_op(input logic [3:0] op);
    return (op > 4'd9) || (!HYP && op >= 4'd6);
  endfunction

  // Mathematical meaning of each operation, independent of CORDIC mechanics
  function automatic int model(input logic [3:0] op, input int xv, input int yv, input int zv);
    real x, y, z;
    x = rv(xv); y = rv(yv); z = rv(zv);
    if (unused_op(op)) return 0;
    case (op)
      4'd0: return q($sin(z));
      4'd1: return q($cos(z));
      4'd2: return q($atan2(y, x));
      4'd3: return q($sqrt(x * x + y * y));
      4'd4: return q(x * z);
      4'd5: return q(y / x);
      4'd6: return q($sinh(z));
      4'd7: return q($cosh(z));
      4'd8: return q($atanh(y / x));
      4'd9: return q($sqrt(x * x - y * y));
      default: return 0;
    endcase
  endfunction

  // Start one operation, scramble inputs after the start edge, measure latency
  task automatic run_op(input logic [3:0] op, input int xv, input int yv, input int zv,
                        input bit hold, output int res);
    int lat;
    @(negedge clk);
    operation = op; x_in = xv; y_in = yv; z_in = zv; enable = 1'b1;
    @(posedge clk); #1;
    check("done_clr", done, 0, 0);
    enable    = hold;
    operation = 4'($urandom);
    x_in = $urandom; y_in = $urandom; z_in = $urandom;
    lat = -1;
    for (int c = 1; c <= N + 8; c++) begin
      @(posedge clk); #1;
      if (hold && c == N) enable = 1'b0;
      if (done) begin
        lat = c;
        break;
      end
    end
    enable = 1'b0;
    check("latency", lat, N + 2, 0);
    res = result;
  endtask

  initial begin
    int res, xv, yv, zv, exp, seen;
    logic [3:0] op;

    rst = 1'b1; enable = 1'b0; operation = '0; x_in = '0; y_in = '0; z_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_done", done, 0, 0);
    check("rst_result", result, 0, 0);
    @(negedge clk) rst = 1'b0;

    run_op(OP4(4), q(2.5), 0, q(1.5), 1'b0, res);
    check("mult", res, q(3.75), TOL);
    run_op(OP4(0), 0, 0, q(0.523599), 1'b0, res);
    check("sin", res, q(0.5), TOL);
    run_op(OP4(1), 0, 0, 0, 1'b0, res);
    check("cos", res, q(1.0), TOL);
    run_op(OP4(5), q(4.0), q(2.0), 0, 1'b0, res);
    check("div", res, q(0.5), TOL);
    run_op(OP4(3), q(3.0), q(4.0), 0, 1'b0, res);
    check("mod", res, q(5.0), TOL);
    run_op(OP4(2), q(1.0), q(1.0), 0, 1'b0, res);
    check("atan", res, q(0.785398), TOL);
    run_op(OP4(7), 0, 0, q(0.5), 1'b0, res);
    check("cosh", res, HYP ? q(1.127626) : 0, HYP ? TOL : 0);
    run_op(OP4(8), q(1.0), q(0.5), 0, 1'b0, res);
    check("atanh", res, HYP ? q(0.549306) : 0, HYP ? TOL : 0);
    run_op(OP4(15), q(1.0), q(1.0), q(1.0), 1'b0, res);
    check("default_op", res, 0, 0);

    // enable held through ITER, then result must stay put while done
    run_op(OP4(4), q(-1.25), 0, q(0.75), 1'b1, res);
    check("mult_hold_en", res, q(-0.9375), TOL);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("stable_done", done, 1, 0);
      check("stable_res", result, q(-0.9375), TOL);
    end

    // reset mid-iteration aborts the operation
    @(negedge clk);
    operation = OP4(4); x_in = q(3.0); z_in = q(1.25); enable = 1'b1;
    @(posedge clk); #1 enable = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_done", done, 0, 0);
    check("midrst_result", result, 0, 0);
    @(negedge clk) rst = 1'b0;
    seen = 0;
    repeat (N + 6) begin
      @(posedge clk); #1;
      if (done) seen = 1;
    end
    check("no_done_after_rst", seen, 0, 0);
    run_op(OP4(4), q(3.0), 0, q(1.25), 1'b0, res);
    check("mult_after_rst", res, q(3.75), TOL);

    // reset wins over a simultaneous enable
    @(negedge clk);
    rst = 1'b1; enable = 1'b1; operation = OP4(4); x_in = q(1.0); z_in = q(1.0);
    @(posedge clk); #1;
    check("rst_prio_done", done, 0, 0);
    @(negedge clk) begin rst = 1'b0; enable = 1'b0; end
    seen = 0;
    repeat (N + 6) begin
      @(posedge clk); #1;
      if (done) seen = 1;
    end
    check("rst_prio_no_start", seen, 0, 0);

    // randomized operations inside each operation's valid range
    for (int t = 0; t < 40; t++) begin
      op = 4'($urandom_range(0, 15));
      xv = $urandom; yv = $urandom; zv = $urandom;
      case (op)
        4'd0, 4'd1: zv = q(urange(-1.5, 1.5));
        4'd2, 4'd3: begin xv = q(urange(0.5, 4.0)); yv = q(urange(-4.0, 4.0)); end
        4'd4: begin xv = q(urange(-8.0, 8.0)); zv = q(urange(-1.9, 1.9)); end
        4'd5: begin xv = q(urange(1.0, 8.0)); yv = q(rv(xv) * urange(-1.9, 1.9)); end
        4'd6, 4'd7: zv = q(urange(-1.0, 1.0));
        4'd8, 4'd9: begin xv = q(urange(1.0, 2.0)); yv = q(rv(xv) * urange(-0.7, 0.7)); end
        default: ;
      endcase
      exp = model(op, xv, yv, zv);
      run_op(op, xv, yv, zv, (t % 5) == 0, res);
      check($sformatf("rand_op%0d", op), res, exp, unused_op(op) ? 0 : TOL);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  function automatic logic [3:0] OP4(input int v);
    return 4'(v);
  endfunction

endmodule
